// File: rtl/tcore_param.sv
// Shared core parameters and iomem responder types.
package tcore_param;

    localparam int XLEN     = 32;
    localparam int BLK_SIZE = 128;

    typedef enum logic [1:0] {
        IOMEM_IDLE,
        IOMEM_WAIT,
        IOMEM_RESP
    } iomem_state_e;

    localparam logic [15:0] IOMEM_LFSR_SEED = 16'hACE1;

    // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting toward bit 0
    function automatic logic [15:0] iomem_lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/iomem_lfsr.sv
// 16-bit Fibonacci LFSR with enable; reloads its seed on reset.
module iomem_lfsr
    import tcore_param::*;
#(
    parameter logic [15:0] SEED = IOMEM_LFSR_SEED
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_o <= SEED;
        end else if (en_i) begin
            lfsr_o <= iomem_lfsr_next(lfsr_o);
        end
    end

endmodule

// File: rtl/iomem_responder.sv
// Line-based main-memory responder for the iomem interface with programmable latency.
// Optional latency jitter when IOMEM_LAT_JITTER_EN is defined.
module iomem_responder #(
    parameter int          XLEN      = tcore_param::XLEN,
    parameter int          BLK_SIZE  = tcore_param::BLK_SIZE,
    parameter int          MEM_DEPTH = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          READ_LAT  = 4,
    parameter int          WRITE_LAT = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  iomem_valid_i,
    output logic                  iomem_ready_o,
    input  logic [BLK_SIZE/8-1:0] iomem_wstrb_i,
    input  logic [XLEN-1:0]       iomem_addr_i,
    input  logic [BLK_SIZE-1:0]   iomem_wdata_i,
    output logic [BLK_SIZE-1:0]   iomem_rdata_o,
    output logic                  oob_o
);

    import tcore_param::*;

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = BLK_SIZE / 8;
    localparam int CNT_W  = 8;

    iomem_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    lat_load;
    logic [IDX_W-1:0]    idx_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [BLK_SIZE-1:0] wdata_q;
    logic                oob_q;
    logic                accept;
    logic                is_read;
    logic                in_range;
    logic [XLEN-1:0]     offset;
    logic [BLK_SIZE-1:0] mem [MEM_DEPTH];

    assign accept  = (state_q == IOMEM_IDLE) && iomem_valid_i;
    assign is_read = (wstrb_q == '0);

    // Unsigned subtraction: an address below the base wraps high and fails the range check too
    assign offset   = iomem_addr_i - XLEN'(BASE_ADDR);
    assign in_range = (iomem_addr_i >= XLEN'(BASE_ADDR)) && ((offset >> 4) < XLEN'(MEM_DEPTH));

`ifdef IOMEM_LAT_JITTER_EN
    logic [15:0] lfsr_q;

    iomem_lfsr #(
        .SEED   (IOMEM_LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (accept),
        .lfsr_o (lfsr_q)
    );
`endif

    always_comb begin
        lat_load = (iomem_wstrb_i == '0) ? CNT_W'(READ_LAT - 1) : CNT_W'(WRITE_LAT - 1);
`ifdef IOMEM_LAT_JITTER_EN
        lat_load = lat_load + CNT_W'(lfsr_q[2:0]);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IOMEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        iomem_ready_o = 1'b0;
        oob_o         = 1'b0;
        unique case (state_q)
            IOMEM_IDLE: begin
                if (iomem_valid_i) begin
                    state_d = IOMEM_WAIT;
                end
            end
            IOMEM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IOMEM_RESP;
                end
            end
            IOMEM_RESP: begin
                iomem_ready_o = 1'b1;
                oob_o         = oob_q;
                state_d       = IOMEM_IDLE;
            end
            default: state_d = IOMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= lat_load;
        end else if ((state_q == IOMEM_WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Request is frozen at acceptance; input changes after that are ignored
    always_ff @(posedge clk_i) begin
        if (accept) begin
            idx_q   <= offset[IDX_W+3:4];
            wstrb_q <= iomem_wstrb_i;
            wdata_q <= iomem_wdata_i;
            oob_q   <= !in_range;
        end
    end

    // Read data lands on the edge entering RESP so it is valid alongside ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iomem_rdata_o <= '0;
        end else if ((state_q == IOMEM_WAIT) && (cnt_q == '0) && is_read) begin
            iomem_rdata_o <= oob_q ? '0 : mem[idx_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if ((state_q == IOMEM_RESP) && !is_read && !oob_q) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_iomem_responder.sv
// Randomized bench for iomem_responder against a line-array reference model.
module tb_iomem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          RLAT  = 4;
    localparam int          WLAT  = 2;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         iomem_valid_i;
    logic         iomem_ready_o;
    logic [15:0]  iomem_wstrb_i;
    logic [31:0]  iomem_addr_i;
    logic [127:0] iomem_wdata_i;
    logic [127:0] iomem_rdata_o;
    logic         oob_o;

    logic [127:0] ref_mem [DEPTH];
    logic [127:0] ref_rdata;
    logic [15:0]  ref_lfsr;
    int           checks   = 0;
    int           failures = 0;
    int           lines [17];

    iomem_responder dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .iomem_valid_i (iomem_valid_i),
        .iomem_ready_o (iomem_ready_o),
        .iomem_wstrb_i (iomem_wstrb_i),
        .iomem_addr_i  (iomem_addr_i),
        .iomem_wdata_i (iomem_wdata_i),
        .iomem_rdata_o (iomem_rdata_o),
        .oob_o         (oob_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_oob(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a < BASE) || ((off >> 4) >= 32'(DEPTH));
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 4);
    endfunction

    // Taps 16,14,13,11 counted from the output end (bit 0 = stage 16)
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11];
        return {fb, s[15:1]};
    endfunction

    // Expected latency (request edge to ready) for the next accepted request
    function automatic int next_lat(input logic [15:0] strb);
        int lat;
        lat = (strb == 16'h0) ? RLAT : WLAT;
`ifdef IOMEM_LAT_JITTER_EN
        lat += int'(ref_lfsr[2:0]);
        ref_lfsr = lfsr_step(ref_lfsr);
`endif
        return lat;
    endfunction

    function automatic logic [31:0] line_addr(input int line);
        return BASE + 32'(line) * 32'd16 + 32'($urandom_range(0, 15));
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_req(input string tag, input logic [31:0] addr, input logic [15:0] strb,
                          input logic [127:0] wdata, input bit drop_early, output logic [127:0] rd);
        int  exp_lat;
        int  k;
        bit  oob;
        oob     = ref_oob(addr);
        exp_lat = next_lat(strb);
        iomem_valid_i = 1'b1;
        iomem_addr_i  = addr;
        iomem_wstrb_i = strb;
        iomem_wdata_i = wdata;
        k = 0;
        do begin
            tick();
            k++;
            if (drop_early && k == 1) begin
                iomem_valid_i = 1'b0;
                iomem_addr_i  = $urandom;
                iomem_wstrb_i = 16'($urandom);
                iomem_wdata_i = {$urandom, $urandom, $urandom, $urandom};
            end
        end while (!iomem_ready_o && k < 64);
        check({tag, "_lat"}, 128'(k), 128'(exp_lat + 1));
        if (strb == 16'h0) begin
            ref_rdata = oob ? 128'h0 : ref_mem[ref_idx(addr)];
        end else if (!oob) begin
            for (int i = 0; i < 16; i++) begin
                if (strb[i]) ref_mem[ref_idx(addr)][i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        check({tag, "_rdata"}, iomem_rdata_o, ref_rdata);
        check({tag, "_oob"}, 128'(oob_o), 128'(oob));
        rd = iomem_rdata_o;
        iomem_valid_i = 1'b0;
        tick();
        check({tag, "_pulse"}, 128'(iomem_ready_o), 128'h0);
    endtask

    // Start a write and pull reset at cycle at_k after acceptance; the write must never land
    task automatic reset_abort(input string tag, input int line, input bit in_resp);
        int exp_lat;
        int at_k;
        exp_lat = next_lat(16'hFFFF);
        at_k = in_resp ? exp_lat + 1 : exp_lat;
        iomem_valid_i = 1'b1;
        iomem_addr_i  = line_addr(line);
        iomem_wstrb_i = 16'hFFFF;
        iomem_wdata_i = ~ref_mem[line];
        for (int k = 1; k <= at_k; k++) tick();
        check({tag, "_pre_rdy"}, 128'(iomem_ready_o), 128'(in_resp));
        rst_ni = 1'b0;
        #1;
        check({tag, "_rdy"}, 128'(iomem_ready_o), 128'h0);
        check({tag, "_rd0"}, iomem_rdata_o, 128'h0);
        iomem_valid_i = 1'b0;
        tick();
        rst_ni    = 1'b1;
        ref_rdata = '0;
        ref_lfsr  = 16'hACE1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rd;
        logic [127:0] d0;
        int e1, e2;
        int op;
        int ln;
        logic [31:0] a;

        ref_lfsr  = 16'hACE1;
        ref_rdata = '0;
        rst_ni        = 1'b0;
        iomem_valid_i = 1'b0;
        iomem_addr_i  = '0;
        iomem_wstrb_i = '0;
        iomem_wdata_i = '0;
        for (int i = 0; i < 16; i++) lines[i] = i;
        lines[16] = DEPTH - 1;

        repeat (3) tick();
        check("rst_ready", 128'(iomem_ready_o), 128'h0);
        check("rst_rdata", iomem_rdata_o, 128'h0);
        check("rst_oob", 128'(oob_o), 128'h0);
        rst_ni = 1'b1;
        tick();
        check("post_rst_ready", 128'(iomem_ready_o), 128'h0);

        foreach (lines[i]) begin
            do_req("init", line_addr(lines[i]), 16'hFFFF,
                   {$urandom, $urandom, $urandom, $urandom}, 1'b0, rd);
        end

        d0 = 128'h0123456789ABCDEF0123456789ABCDEF;
        do_req("wr_full", 32'h8000_0010, 16'hFFFF, d0, 1'b0, rd);
        do_req("rd_full", 32'h8000_0010, 16'h0000, '0, 1'b0, rd);
        check("rd_full_const", rd, d0);

        do_req("wr_ones", 32'h8000_0020, 16'hFFFF, {128{1'b1}}, 1'b0, rd);
        do_req("wr_part", 32'h8000_0020, 16'h000F, 128'hDEADBEEF, 1'b0, rd);
        do_req("rd_part", 32'h8000_0020, 16'h0000, '0, 1'b0, rd);
        check("rd_part_const", rd, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEADBEEF});

        do_req("oob_lo", 32'h7FFF_FFF0, 16'h0000, '0, 1'b0, rd);
        do_req("oob_hi", 32'h8001_0000, 16'h0000, '0, 1'b0, rd);
        do_req("oob_wr", 32'h8001_0000, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, 1'b0, rd);
        do_req("rd_l0", BASE, 16'h0000, '0, 1'b0, rd);
        do_req("rd_last", BASE + 32'((DEPTH - 1) * 16), 16'h0000, '0, 1'b0, rd);

        // Back-to-back reads with valid held throughout
        e1 = next_lat(16'h0) + 1;
        e2 = e1 + 1 + next_lat(16'h0) + 1;
        iomem_valid_i = 1'b1;
        iomem_addr_i  = line_addr(3);
        iomem_wstrb_i = 16'h0;
        for (int k = 1; k <= e2 + 2; k++) begin
            tick();
            check("b2b_ready", 128'(iomem_ready_o), 128'((k == e1) || (k == e2)));
            if (k == e2) begin
                iomem_valid_i = 1'b0;
                check("b2b_rdata", iomem_rdata_o, ref_mem[3]);
            end
        end
        ref_rdata = ref_mem[3];

        reset_abort("rst_wait", 5, 1'b0);
        do_req("rd_after_rst_wait", line_addr(5), 16'h0000, '0, 1'b0, rd);
        reset_abort("rst_resp", 6, 1'b1);
        do_req("rd_after_rst_resp", line_addr(6), 16'h0000, '0, 1'b0, rd);

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 7);
            ln = lines[$urandom_range(0, 16)];
            case (op)
                0, 1, 2, 3: do_req("rnd_rd", line_addr(ln), 16'h0, '0, ($urandom_range(0, 3) == 0), rd);
                4, 5: do_req("rnd_wp", line_addr(ln), 16'($urandom),
                             {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) == 0), rd);
                6: do_req("rnd_wf", line_addr(ln), 16'hFFFF,
                          {$urandom, $urandom, $urandom, $urandom}, 1'b0, rd);
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h7FFF_FFF0;
                        1: a = 32'h8001_0000;
                        2: a = $urandom_range(0, 32'h7FFF_FFFF);
                        default: a = BASE + 32'h0001_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
                    endcase
                    do_req("rnd_oob", a, ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom),
                           {$urandom, $urandom, $urandom, $urandom}, 1'b0, rd);
                end
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end

        foreach (lines[i]) begin
            do_req("final_rd", line_addr(lines[i]), 16'h0, '0, 1'b0, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
